// File: rtl/instr_sequencer.sv
// instr_sequencer: buffers 16-bit instructions in a FIFO and issues them one
// at a time to a CPU with a load / start / wait-low / wait-high handshake.
// Ports: clk; reset (async, active-high); wr_en/wr_data push the queue;
// go starts a run; cpu_w is the CPU idle flag; cpu_in/cpu_load/cpu_s drive
// the CPU; full/empty, busy, done, err and retired report status.
module instr_sequencer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic        go,
    input  logic        cpu_w,
    output logic [15:0] cpu_in,
    output logic        cpu_load,
    output logic        cpu_s,
    output logic        full,
    output logic        empty,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  retired
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, START, WAIT_LOW, WAIT_HIGH
    } state_t;

    state_t state, state_nx;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nx;
    logic [AW:0]   count, count_after, count_nx;
    logic [TW-1:0] tcnt;

    logic push, pop, tmo, wh_exit, start_run, empty_done;
    logic [15:0] head_nx, cpu_in_nx;
    logic cpu_load_nx, cpu_s_nx, busy_nx, done_nx, err_nx;
    logic full_nx, empty_nx;

    assign push        = wr_en && !full;
    assign wh_exit     = (state == WAIT_HIGH) && cpu_w;
    assign pop         = wh_exit;
    // A CPU that finishes on the last allowed cycle still counts as done.
    assign tmo         = (state == WAIT_LOW || state == WAIT_HIGH)
                         && (tcnt == TW'(TIMEOUT - 1)) && !wh_exit;
    assign start_run   = (state == IDLE) && go && cpu_w && !empty;
    assign empty_done  = (state == IDLE) && go && cpu_w && empty;
    assign count_after = count - {{AW{1'b0}}, pop} + {{AW{1'b0}}, push};
    assign count_nx    = tmo ? '0 : count_after;
    assign rd_nx       = rd_ptr + 1'b1;

    // Head seen after this edge; a lone entry being popped is replaced
    // by the word written in the same cycle.
    always_comb begin
        head_nx = mem[rd_ptr];
        if (pop) begin
            if (count == (AW+1)'(1)) head_nx = wr_data;
            else                     head_nx = mem[rd_nx];
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (start_run) state_nx = LOAD;
            LOAD:      state_nx = START;
            START:     state_nx = WAIT_LOW;
            WAIT_LOW: begin
                if (tmo)         state_nx = IDLE;
                else if (!cpu_w) state_nx = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (tmo)        state_nx = IDLE;
                else if (cpu_w) state_nx = (count_after == '0) ? IDLE : LOAD;
            end
            default:   state_nx = IDLE;
        endcase
    end

    // Output logic: next values for the output registers
    always_comb begin
        cpu_in_nx   = cpu_in;
        if (state_nx == LOAD) cpu_in_nx = head_nx;
        cpu_load_nx = (state_nx == LOAD);
        cpu_s_nx    = (state_nx == START);
        busy_nx     = (state_nx != IDLE);
        done_nx     = empty_done || (wh_exit && count_after == '0);
        err_nx      = err;
        if (start_run) err_nx = 1'b0;
        else if (tmo)  err_nx = 1'b1;
        full_nx     = (count_nx == (AW+1)'(DEPTH));
        empty_nx    = (count_nx == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_in   <= '0;
            cpu_load <= 1'b0;
            cpu_s    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            full     <= 1'b0;
            empty    <= 1'b1;
            retired  <= '0;
        end else begin
            cpu_in   <= cpu_in_nx;
            cpu_load <= cpu_load_nx;
            cpu_s    <= cpu_s_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            err      <= err_nx;
            full     <= full_nx;
            empty    <= empty_nx;
            if (pop) retired <= retired + 8'd1;
        end
    end

    // Queue pointers; a timeout flushes everything including a same-cycle write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (tmo) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_nx;
            count <= count_after;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Per-instruction timer, restarted as each instruction is started.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tcnt <= '0;
        else if (state == START)
            tcnt <= '0;
        else if (state == WAIT_LOW || state == WAIT_HIGH)
            tcnt <= tcnt + 1'b1;
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: scoreboard of expected issued words,
// CPU handshake model and directed plus randomized runs.
module tb_instr_sequencer;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        go;
    logic        cpu_w;
    logic [15:0] cpu_in;
    logic        cpu_load, cpu_s, full, empty, busy, done, err;
    logic [7:0]  retired;

    instr_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .go(go), .cpu_w(cpu_w), .cpu_in(cpu_in), .cpu_load(cpu_load),
        .cpu_s(cpu_s), .full(full), .empty(empty), .busy(busy),
        .done(done), .err(err), .retired(retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];
    int occ = 0;
    int exp_ret = 0;
    int gen = 0;
    int done_cnt = 0;
    int load_cnt = 0;
    int d1 = 2;
    int d2 = 4;
    bit hang = 0;

    task automatic chk(string nm, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // CPU model: after a start strobe, drop w after d1 cycles and raise it
    // d2 cycles later; in hang mode hold w low until released.
    initial begin
        int g, a, b;
        cpu_w = 1'b1;
        forever begin
            @(negedge clk);
            if (cpu_s && !reset) begin
                g = gen; a = d1; b = d2;
                if (hang) begin
                    @(negedge clk);
                    cpu_w = 1'b0;
                    while (hang) @(negedge clk);
                    cpu_w = 1'b1;
                end else begin
                    repeat (a) @(negedge clk);
                    cpu_w = 1'b0;
                    repeat (b) @(negedge clk);
                    cpu_w = 1'b1;
                    if (g == gen) begin
                        occ--;
                        exp_ret++;
                    end
                end
            end
        end
    end

    // Monitor: every load must carry the next expected word, followed by
    // exactly one start strobe with the word held.
    initial begin
        bit exp_s;
        logic [15:0] last;
        exp_s = 0;
        last = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_s = 0;
            end else begin
                if (exp_s) begin
                    chk("cpu_s after load", int'(cpu_s), 1);
                    chk("cpu_in held in start", int'(cpu_in), int'(last));
                    exp_s = 0;
                end else begin
                    chk("cpu_s without load", int'(cpu_s), 0);
                end
                if (cpu_load) begin
                    load_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected cpu_load", int'(cpu_load), 0);
                    end else begin
                        last = exp_q.pop_front();
                        chk("cpu_in at load", int'(cpu_in), int'(last));
                    end
                    exp_s = 1;
                end
                if (done) done_cnt++;
            end
        end
    end

    task automatic push_word(logic [15:0] w);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = w;
        if (occ < DEPTH) begin
            exp_q.push_back(w);
            occ++;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_go();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_idle(string nm);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk({nm, " idle timeout"}, int'(busy), 0);
    endtask

    task automatic run_check(string nm);
        int d0;
        d0 = done_cnt;
        do_go();
        wait_idle(nm);
        @(negedge clk);
        chk({nm, " done pulses"}, done_cnt - d0, 1);
        chk({nm, " retired"}, int'(retired), exp_ret & 255);
        chk({nm, " empty"}, int'(empty), 1);
        chk({nm, " words left"}, exp_q.size(), 0);
        chk({nm, " busy"}, int'(busy), 0);
    endtask

    initial begin
        logic [15:0] prog [7];
        int d0, l0, n;
        prog = '{16'hD00A, 16'hD103, 16'hC041, 16'hA188,
                 16'hA900, 16'hB2A0, 16'hB8C0};
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; go = 1'b0;
        #12;
        chk("rst busy", int'(busy), 0);
        chk("rst empty", int'(empty), 1);
        chk("rst full", int'(full), 0);
        chk("rst done", int'(done), 0);
        chk("rst err", int'(err), 0);
        chk("rst retired", int'(retired), 0);
        chk("rst cpu_in", int'(cpu_in), 0);
        chk("rst cpu_load", int'(cpu_load), 0);
        @(negedge clk);
        reset = 1'b0;

        // go on an empty queue
        d0 = done_cnt;
        do_go();
        @(negedge clk);
        @(negedge clk);
        chk("empty go done", done_cnt - d0, 1);
        chk("empty go loads", load_cnt, 0);
        chk("empty go busy", int'(busy), 0);

        d1 = 2; d2 = 4;
        push_word(16'hD00A);
        run_check("single");

        for (int i = 0; i < 7; i++) push_word(prog[i]);
        l0 = load_cnt;
        run_check("prog7");
        chk("prog7 loads", load_cnt - l0, 7);

        for (int i = 0; i < 9; i++) begin
            push_word(16'($urandom));
            if (i == 6) chk("full after 7", int'(full), 0);
            if (i >= 7) chk("full after 8+", int'(full), 1);
        end
        chk("full model occ", occ, DEPTH);
        l0 = load_cnt;
        run_check("full");
        chk("full loads", load_cnt - l0, DEPTH);

        // append during WAIT_HIGH
        push_word(16'h1111);
        l0 = load_cnt;
        d0 = done_cnt;
        do_go();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!cpu_w) break;
        end
        push_word(16'h2222);
        wait_idle("append");
        @(negedge clk);
        chk("append loads", load_cnt - l0, 2);
        chk("append done", done_cnt - d0, 1);
        chk("append retired", int'(retired), exp_ret & 255);
        chk("append words left", exp_q.size(), 0);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, DEPTH);
            d1 = $urandom_range(1, 4);
            d2 = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) push_word(16'($urandom));
            chk("rand full", int'(full), int'(occ == DEPTH));
            run_check("rand");
        end

        // timeout
        hang = 1;
        push_word(16'hAAAA);
        push_word(16'hBBBB);
        push_word(16'hCCCC);
        d0 = done_cnt;
        do_go();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cpu_s) break;
        end
        repeat (TIMEOUT) @(negedge clk);
        chk("err before timeout", int'(err), 0);
        @(negedge clk);
        chk("err at timeout", int'(err), 1);
        chk("tmo busy", int'(busy), 0);
        chk("tmo empty", int'(empty), 1);
        chk("tmo retired", int'(retired), exp_ret & 255);
        chk("tmo no done", done_cnt - d0, 0);
        exp_q.delete();
        occ = 0;
        hang = 0;
        d1 = 2; d2 = 3;
        push_word(16'h3333);
        d0 = done_cnt;
        do_go();
        chk("go clears err", int'(err), 0);
        wait_idle("post tmo");
        @(negedge clk);
        chk("post tmo done", done_cnt - d0, 1);
        chk("post tmo retired", int'(retired), exp_ret & 255);

        // reset while in WAIT_HIGH
        d1 = 2; d2 = 6;
        push_word(16'h4444);
        push_word(16'h5555);
        do_go();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!cpu_w) break;
        end
        @(negedge clk);
        #2 reset = 1'b1;
        gen++;
        exp_q.delete();
        occ = 0;
        exp_ret = 0;
        #1;
        chk("mid rst busy", int'(busy), 0);
        chk("mid rst empty", int'(empty), 1);
        chk("mid rst retired", int'(retired), 0);
        chk("mid rst cpu_in", int'(cpu_in), 0);
        chk("mid rst full", int'(full), 0);
        chk("mid rst err", int'(err), 0);
        @(negedge clk);
        reset = 1'b0;
        l0 = load_cnt;
        for (int i = 0; i < 100; i++) begin
            if (cpu_w) break;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("no load after rst", load_cnt - l0, 0);
        chk("post rst busy", int'(busy), 0);
        chk("post rst retired", int'(retired), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
